up5bit_counter_dual_source: RTL and testbench

- Two independent 5-bit up counters inside a single clock domain.
- out0 counts rising edges of the system clock clk0.
- out1 counts rising edges of the asynchronous event input clk1, which is synchronised into clk0 and edge-detected.
- Used as a fabric bring-up and verification block; both counts are visible as plain registered outputs.

---
 rtl/up5bit_counter_dual_source.sv | 47 ++++
 tb/tb_up5bit_counter_dual_source.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/up5bit_counter_dual_source.sv
// Two independent WIDTH-bit up counters: out0 counts clk0 edges, out1 counts synchronised clk1 rises.
// Latency: out0 registered, 1 edge; out1 updates SYNC_STAGES+1 edges after a clk1 rise. Backpressure: none.
module up5bit_counter_dual_source #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk0,
  input  logic             reset,
  input  logic             clk1,
  output logic [2:0]       gfpga_io,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   sync_out;
  logic                   rise;

  assign gfpga_io = 3'b000;
  assign sync_out = sync_q[SYNC_STAGES-1];
  // A clk1 level already high at reset release must not count: only arm once a settled low is seen.
  assign rise     = sync_out & ~prev_q & armed_q;

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      out0    <= '0;
      out1    <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], clk1};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= sync_out;
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_out);
      out0    <= out0 + WIDTH'(1);
      if (rise) begin
        out1 <= out1 + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_up5bit_counter_dual_source.sv
// Bench for up5bit_counter_dual_source: per-cycle out0 model, scoreboard of expected out1 steps,
// table of clk1 hold segments, and hand-written reset / wrap sequences.
module tb_up5bit_counter_dual_source;

  localparam int WIDTH = 5;
  localparam int SYNC  = 2;

  logic             clk0;
  logic             reset;
  logic             clk1;
  logic [2:0]       gfpga_io;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;

  up5bit_counter_dual_source #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk0     (clk0),
    .reset    (reset),
    .clk1     (clk1),
    .gfpga_io (gfpga_io),
    .out0     (out0),
    .out1     (out1)
  );

  typedef struct {
    logic [WIDTH-1:0] val;
    int               edge_n;
  } sb_t;

  typedef struct {
    logic             lvl;
    int               hold;
    logic [WIDTH-1:0] exp_out1;
  } vec_t;

  sb_t              sb_q[$];
  vec_t             tbl[8];
  int               n_vec = 0;
  int               n_err = 0;
  int               edge_cnt = 0;
  int               rel_edge = 0;
  logic [WIDTH-1:0] exp_cnt = '0;
  logic [WIDTH-1:0] last_out1 = '0;

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  always @(posedge clk0) edge_cnt++;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: out0 against edges since release, out1 changes against the scoreboard.
  always @(negedge clk0) begin
    chk("gfpga_io", int'(gfpga_io), 0);
    if (reset) begin
      chk("out0_rst", int'(out0), 0);
      chk("out1_rst", int'(out1), 0);
      last_out1 = '0;
    end else begin
      chk("out0_seq", int'(out0), (edge_cnt - rel_edge) & 31);
      if (out1 != last_out1) begin
        if (sb_q.size() == 0) begin
          chk("out1_spurious", int'(out1), int'(last_out1));
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("out1_step", int'(out1), int'(e.val));
          chk("out1_latency_ok",
              int'((edge_cnt - e.edge_n) >= SYNC && (edge_cnt - e.edge_n) <= SYNC + 2), 1);
        end
        last_out1 = out1;
      end else if (sb_q.size() > 0 && (edge_cnt - sb_q[0].edge_n) > SYNC + 2) begin
        chk("out1_timeout", int'(out1), int'(sb_q[0].val));
        void'(sb_q.pop_front());
      end
    end
  end

  // Called just after a negedge; a 0->1 change of clk1 schedules one expected out1 step.
  task automatic drive(input logic lvl, input int hold);
    if (lvl && !clk1) begin
      exp_cnt = exp_cnt + 1'b1;
      sb_q.push_back('{val: exp_cnt, edge_n: edge_cnt});
    end
    clk1 = lvl;
    repeat (hold) @(negedge clk0);
  endtask

  task automatic assert_reset();
    #2;
    sb_q.delete();
    exp_cnt = '0;
    reset   = 1'b1;
    repeat (2) @(negedge clk0);
  endtask

  task automatic release_reset();
    #2;
    reset    = 1'b0;
    rel_edge = edge_cnt;
    @(negedge clk0);
  endtask

  task automatic wait_out0(input int target);
    for (int i = 0; i < 40 && int'(out0) != target; i++) @(negedge clk0);
    chk("wait_out0", int'(out0), target);
  endtask

  initial begin
    tbl[0] = '{1'b1, 100, 5'd1};
    tbl[1] = '{1'b0, 100, 5'd1};
    tbl[2] = '{1'b1,   5, 5'd2};
    tbl[3] = '{1'b0,   5, 5'd2};
    tbl[4] = '{1'b1,   6, 5'd3};
    tbl[5] = '{1'b0,   7, 5'd3};
    tbl[6] = '{1'b1,   5, 5'd4};
    tbl[7] = '{1'b0,   5, 5'd4};

    reset = 1'b1;
    clk1  = 1'b0;
    repeat (3) @(negedge clk0);
    release_reset();

    // Constant-level holds and isolated events
    drive(1'b0, 4);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].lvl, tbl[i].hold);
      chk("tbl_out1", int'(out1), int'(tbl[i].exp_out1));
    end

    // 32 clk1 events at 8 clk0 period: out1 runs 1..31 then wraps to 0
    assert_reset();
    release_reset();
    drive(1'b0, 4);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    chk("out1_wrap", int'(out1), 0);

    // out1 updates land on the out0 31->0 wrap edge
    for (int i = 0; i < 2; i++) begin
      wait_out0(29);
      drive(1'b1, 4);
      drive(1'b0, 4);
      chk("out1_at_out0_wrap", int'(out1), i + 1);
    end

    // clk1 high through reset release: no count until a fresh rise
    drive(1'b1, 6);
    assert_reset();
    release_reset();
    drive(1'b1, 10);
    drive(1'b0, 5);
    chk("out1_high_at_release", int'(out1), 0);
    drive(1'b1, 6);
    chk("out1_first_rise", int'(out1), 1);
    drive(1'b0, 5);

    // Asynchronous reset mid-count at out0=13, out1=7
    assert_reset();
    release_reset();
    drive(1'b0, 3);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    wait_out0(13);
    chk("mid_out1", int'(out1), 7);
    #2;
    sb_q.delete();
    exp_cnt = '0;
    reset   = 1'b1;
    #1;
    chk("async_rst_out0", int'(out0), 0);
    chk("async_rst_out1", int'(out1), 0);
    chk("async_rst_gfpga", int'(gfpga_io), 0);
    repeat (2) @(negedge clk0);
    release_reset();
    drive(1'b0, 4);
    drive(1'b1, 6);
    chk("restart_out1", int'(out1), 1);
    drive(1'b0, 8);

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
